// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl
// Sequencer that owns the PLL reset, power-down and dynamic-configuration pins.
// It performs bring-up after reset, per-output or broadcast reconfiguration,
// qualified lock detection with timeout and bounded retry, and automatic relock.
module pll_reconfig_ctrl #(
    parameter int DEF_ODIV      = 100,
    parameter int DEF_DUTY      = 100,
    parameter int DEF_PHASE     = 16,
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int MAX_RETRY     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [2:0]  cfg_sel,
    input  logic [9:0]  cfg_odiv,
    input  logic [9:0]  cfg_duty,
    input  logic [12:0] cfg_phase,
    input  logic        pll_lock,
    output logic        pll_rst,
    output logic        pll_pwd,
    output logic [9:0]  dyn_odiv0,
    output logic [9:0]  dyn_odiv1,
    output logic [9:0]  dyn_odiv2,
    output logic [9:0]  dyn_odiv3,
    output logic [9:0]  dyn_odiv4,
    output logic [9:0]  dyn_duty0,
    output logic [9:0]  dyn_duty1,
    output logic [9:0]  dyn_duty2,
    output logic [9:0]  dyn_duty3,
    output logic [9:0]  dyn_duty4,
    output logic [12:0] dyn_phase0,
    output logic [12:0] dyn_phase1,
    output logic [12:0] dyn_phase2,
    output logic [12:0] dyn_phase3,
    output logic [12:0] dyn_phase4,
    output logic        busy,
    output logic        locked,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        lock_lost
);

    localparam int NUM_OUT  = 5;
    localparam int CNT_W    = 17;
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int RETRY_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    // Terminal counts are compared against the current value, so the
    // transition fires on the cycle the count would reach its target.
    localparam logic [CNT_W-1:0]    RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST  = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0]  RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

    localparam logic [9:0]  DEF_ODIV_V  = 10'(DEF_ODIV);
    localparam logic [9:0]  DEF_DUTY_V  = 10'(DEF_DUTY);
    localparam logic [12:0] DEF_PHASE_V = 13'(DEF_PHASE);

    localparam logic [1:0] ERR_SEL     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        ST_RST_HOLD,
        ST_WAIT_LOCK,
        ST_DONE,
        ST_IDLE,
        ST_FAIL
    } state_e;

    state_e               state;
    logic [CNT_W-1:0]     cyc_cnt;
    logic [SETTLE_W-1:0]  settle_cnt;
    logic [RETRY_W-1:0]   retry_cnt;

    logic                 lock_meta;
    logic                 lock_s;

    logic [9:0]           odiv_q  [NUM_OUT];
    logic [9:0]           duty_q  [NUM_OUT];
    logic [12:0]          phase_q [NUM_OUT];

    logic                 loss_detect;
    logic                 accept;
    logic                 sel_bcast;
    logic                 sel_legal;

    // Lock loss is only meaningful once a qualified lock has been reported;
    // it also blocks a request arriving in the same cycle.
    assign loss_detect = (state == ST_IDLE) && locked && !lock_s;
    assign cfg_ready   = ((state == ST_IDLE) && !loss_detect) || (state == ST_FAIL);
    assign accept      = cfg_valid && cfg_ready;
    assign sel_bcast   = (cfg_sel == 3'd7);
    assign sel_legal   = (cfg_sel <= 3'd4) || sel_bcast;

    assign dyn_odiv0  = odiv_q[0];
    assign dyn_odiv1  = odiv_q[1];
    assign dyn_odiv2  = odiv_q[2];
    assign dyn_odiv3  = odiv_q[3];
    assign dyn_odiv4  = odiv_q[4];
    assign dyn_duty0  = duty_q[0];
    assign dyn_duty1  = duty_q[1];
    assign dyn_duty2  = duty_q[2];
    assign dyn_duty3  = duty_q[3];
    assign dyn_duty4  = duty_q[4];
    assign dyn_phase0 = phase_q[0];
    assign dyn_phase1 = phase_q[1];
    assign dyn_phase2 = phase_q[2];
    assign dyn_phase3 = phase_q[3];
    assign dyn_phase4 = phase_q[4];

    // Two-flop synchronizer bringing the asynchronous PLL lock into the clk domain.
    always_ff @(posedge clk) begin
        // NOTE: state elements use non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours, exactly like hardware.
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // Sequencer FSM: owns the PLL pins, status pulses and the dynamic config registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RST_HOLD;
            cyc_cnt    <= '0;
            settle_cnt <= '0;
            retry_cnt  <= '0;
            pll_rst    <= 1'b1;
            pll_pwd    <= 1'b0;
            busy       <= 1'b1;
            locked     <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= '0;
            lock_lost  <= 1'b0;
            // NOTE: the config array drives PLL pins directly, so it is a bank of
            // flops with defined reset values, not a RAM that may power up unknown.
            for (int i = 0; i < NUM_OUT; i++) begin
                odiv_q[i]  <= DEF_ODIV_V;
                duty_q[i]  <= DEF_DUTY_V;
                phase_q[i] <= DEF_PHASE_V;
            end
        end else begin
            // Status pulses are one cycle wide unless re-asserted below.
            done      <= 1'b0;
            err       <= 1'b0;
            lock_lost <= 1'b0;

            unique case (state)
                ST_RST_HOLD: begin
                    if (cyc_cnt == RST_LAST) begin
                        state      <= ST_WAIT_LOCK;
                        cyc_cnt    <= '0;
                        settle_cnt <= '0;
                        pll_rst    <= 1'b0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                ST_WAIT_LOCK: begin
                    cyc_cnt    <= cyc_cnt + 1'b1;
                    settle_cnt <= lock_s ? settle_cnt + 1'b1 : '0;
                    // Qualified lock is checked first so it wins over a
                    // timeout landing in the same cycle.
                    if (lock_s && (settle_cnt == SETTLE_LAST)) begin
                        state  <= ST_DONE;
                        done   <= 1'b1;
                        locked <= 1'b1;
                    end else if (cyc_cnt == TIMEOUT_LAST) begin
                        cyc_cnt <= '0;
                        pll_rst <= 1'b1;
                        if (retry_cnt < RETRY_LIMIT) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= ST_RST_HOLD;
                        end else begin
                            state    <= ST_FAIL;
                            pll_pwd  <= 1'b1;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                            err_code <= ERR_TIMEOUT;
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

                ST_IDLE, ST_FAIL: begin
                    if (loss_detect) begin
                        state     <= ST_RST_HOLD;
                        cyc_cnt   <= '0;
                        retry_cnt <= '0;
                        pll_rst   <= 1'b1;
                        busy      <= 1'b1;
                        locked    <= 1'b0;
                        lock_lost <= 1'b1;
                    end else if (accept && sel_legal) begin
                        for (int i = 0; i < NUM_OUT; i++) begin
                            if (sel_bcast || (cfg_sel == 3'(i))) begin
                                odiv_q[i]  <= cfg_odiv;
                                duty_q[i]  <= cfg_duty;
                                phase_q[i] <= cfg_phase;
                            end
                        end
                        state     <= ST_RST_HOLD;
                        cyc_cnt   <= '0;
                        retry_cnt <= '0;
                        pll_rst   <= 1'b1;
                        pll_pwd   <= 1'b0;
                        busy      <= 1'b1;
                        locked    <= 1'b0;
                    end else if (accept) begin
                        // Illegal target: report it, leave state and config untouched.
                        err      <= 1'b1;
                        err_code <= ERR_SEL;
                    end
                end

                default: begin
                    state   <= ST_RST_HOLD;
                    cyc_cnt <= '0;
                    pll_rst <= 1'b1;
                    pll_pwd <= 1'b0;
                    busy    <= 1'b1;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb_pll_reconfig_ctrl
// Scoreboard bench: each stimulus pushes the completion event it should cause
// (done, err with code, or lock_lost, plus the cycle it is due); a monitor pops
// and compares whenever the DUT raises a pulse.
module tb_pll_reconfig_ctrl;

    typedef enum logic [1:0] {EV_DONE, EV_ERR, EV_LOST} ev_e;

    typedef struct packed {
        ev_e         kind;
        logic [1:0]  code;
        logic        chk_cyc;
        logic [31:0] cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_sel;
    logic [9:0]  cfg_odiv;
    logic [9:0]  cfg_duty;
    logic [12:0] cfg_phase;
    logic        pll_lock;
    logic        pll_rst;
    logic        pll_pwd;
    logic [9:0]  dyn_odiv0, dyn_odiv1, dyn_odiv2, dyn_odiv3, dyn_odiv4;
    logic [9:0]  dyn_duty0, dyn_duty1, dyn_duty2, dyn_duty3, dyn_duty4;
    logic [12:0] dyn_phase0, dyn_phase1, dyn_phase2, dyn_phase3, dyn_phase4;
    logic        busy;
    logic        locked;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic        lock_lost;

    logic [9:0]  d_odiv  [5];
    logic [9:0]  d_duty  [5];
    logic [12:0] d_phase [5];

    logic [9:0]  exp_odiv  [5];
    logic [9:0]  exp_duty  [5];
    logic [12:0] exp_phase [5];

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    pll_reconfig_ctrl #(
        .RST_CYCLES    (4),
        .SETTLE_CYCLES (3),
        .LOCK_TIMEOUT  (20),
        .MAX_RETRY     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_sel    (cfg_sel),
        .cfg_odiv   (cfg_odiv),
        .cfg_duty   (cfg_duty),
        .cfg_phase  (cfg_phase),
        .pll_lock   (pll_lock),
        .pll_rst    (pll_rst),
        .pll_pwd    (pll_pwd),
        .dyn_odiv0  (dyn_odiv0),
        .dyn_odiv1  (dyn_odiv1),
        .dyn_odiv2  (dyn_odiv2),
        .dyn_odiv3  (dyn_odiv3),
        .dyn_odiv4  (dyn_odiv4),
        .dyn_duty0  (dyn_duty0),
        .dyn_duty1  (dyn_duty1),
        .dyn_duty2  (dyn_duty2),
        .dyn_duty3  (dyn_duty3),
        .dyn_duty4  (dyn_duty4),
        .dyn_phase0 (dyn_phase0),
        .dyn_phase1 (dyn_phase1),
        .dyn_phase2 (dyn_phase2),
        .dyn_phase3 (dyn_phase3),
        .dyn_phase4 (dyn_phase4),
        .busy       (busy),
        .locked     (locked),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .lock_lost  (lock_lost)
    );

    assign d_odiv[0]  = dyn_odiv0;
    assign d_odiv[1]  = dyn_odiv1;
    assign d_odiv[2]  = dyn_odiv2;
    assign d_odiv[3]  = dyn_odiv3;
    assign d_odiv[4]  = dyn_odiv4;
    assign d_duty[0]  = dyn_duty0;
    assign d_duty[1]  = dyn_duty1;
    assign d_duty[2]  = dyn_duty2;
    assign d_duty[3]  = dyn_duty3;
    assign d_duty[4]  = dyn_duty4;
    assign d_phase[0] = dyn_phase0;
    assign d_phase[1] = dyn_phase1;
    assign d_phase[2] = dyn_phase2;
    assign d_phase[3] = dyn_phase3;
    assign d_phase[4] = dyn_phase4;

    // Clock generation and cycle index (cycle n = the interval after posedge n).
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_defaults();
        for (int i = 0; i < 5; i++) begin
            exp_odiv[i]  = 10'd100;
            exp_duty[i]  = 10'd100;
            exp_phase[i] = 13'd16;
        end
    endtask

    task automatic model_load(input logic [2:0] sel, input logic [9:0] odiv,
                              input logic [9:0] duty, input logic [12:0] phase);
        for (int i = 0; i < 5; i++) begin
            if (sel == 3'd7 || int'(sel) == i) begin
                exp_odiv[i]  = odiv;
                exp_duty[i]  = duty;
                exp_phase[i] = phase;
            end
        end
    endtask

    task automatic check_dyn(input string tag);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("%s_odiv%0d", tag, i), 64'(d_odiv[i]), 64'(exp_odiv[i]));
            check($sformatf("%s_duty%0d", tag, i), 64'(d_duty[i]), 64'(exp_duty[i]));
            check($sformatf("%s_phase%0d", tag, i), 64'(d_phase[i]), 64'(exp_phase[i]));
        end
    endtask

    task automatic push_ev(input ev_e kind, input logic [1:0] code, input logic chk, input int at);
        exp_t e;
        e.kind    = kind;
        e.code    = code;
        e.chk_cyc = chk;
        e.cyc     = 32'(at);
        sb.push_back(e);
    endtask

    // Drive one request for one cycle; optionally queue the event it should produce
    // 'off' cycles after the drive cycle (off = 0 means the cycle is not checked).
    task automatic send(input logic [2:0] sel, input logic [9:0] odiv, input logic [9:0] duty,
                        input logic [12:0] phase, input logic want_ev, input ev_e kind,
                        input logic [1:0] code, input int off);
        if (want_ev) push_ev(kind, code, off != 0, cyc + off);
        if (sel <= 3'd4 || sel == 3'd7) model_load(sel, odiv, duty, phase);
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        cfg_odiv  = odiv;
        cfg_duty  = duty;
        cfg_phase = phase;
        step(1);
        cfg_valid = 1'b0;
    endtask

    task automatic run_len(input logic level, output int n);
        n = 0;
        while ((pll_rst === level) && n < 200) begin
            n++;
            step(1);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (!(cfg_ready && locked) && n < budget) begin
            step(1);
            n++;
        end
        check({tag, "_reached_idle"}, 64'(cfg_ready && locked), 64'd1);
    endtask

    // Monitor: pops the scoreboard whenever the DUT raises a completion pulse.
    initial begin : monitor
        exp_t e;
        ev_e  k;
        forever begin
            @(posedge clk);
            #1;
            if (done || err || lock_lost) begin
                check("pulse_excl", 64'(done) + 64'(err) + 64'(lock_lost), 64'd1);
                if (sb.size() == 0) begin
                    check("unexpected_event", 64'({done, err, lock_lost}), 64'd0);
                end else begin
                    e = sb.pop_front();
                    k = done ? EV_DONE : (err ? EV_ERR : EV_LOST);
                    check("ev_kind", 64'(k), 64'(e.kind));
                    if (e.chk_cyc) check("ev_cycle", 64'(cyc), 64'(e.cyc));
                    if (e.kind == EV_ERR) check("ev_err_code", 64'(err_code), 64'(e.code));
                    if (e.kind == EV_DONE) begin
                        check("ev_done_locked", 64'(locked), 64'd1);
                        check_dyn("ev_done");
                    end
                    if (e.kind == EV_LOST) check("ev_lost_locked", 64'(locked), 64'd0);
                end
            end
        end
    end

    // Hard time limit so the bench can never hang.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // Main stimulus sequence.
    initial begin : stim
        int t;
        int n;
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_sel   = 3'd0;
        cfg_odiv  = 10'd0;
        cfg_duty  = 10'd0;
        cfg_phase = 13'd0;
        pll_lock  = 1'b0;
        model_defaults();

        // Reset state.
        step(3);
        check("rst_pll_rst", 64'(pll_rst), 64'd1);
        check("rst_pll_pwd", 64'(pll_pwd), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        check("rst_pulses", 64'({done, err, lock_lost}), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        check_dyn("rst");

        // Bring-up: lock from cycle 6 after release, lock_s two cycles later,
        // done three cycles after that.
        rst = 1'b0;
        t   = cyc;
        push_ev(EV_DONE, 2'd0, 1'b1, t + 11);
        run_len(1'b1, n);
        check("bringup_rst_len", 64'(n), 64'd4);
        step(2);
        pll_lock = 1'b1;
        wait_idle(40, "bringup");
        check("bringup_pll_rst", 64'(pll_rst), 64'd0);
        check("bringup_busy", 64'(busy), 64'd0);

        // Reconfigure output 2 only.
        t = cyc;
        send(3'd2, 10'd200, 10'd200, 13'd32, 1'b1, EV_DONE, 2'd0, 8);
        check_dyn("rcfg_next");
        check("rcfg_ready_low", 64'(cfg_ready), 64'd0);
        check("rcfg_locked_low", 64'(locked), 64'd0);
        run_len(1'b1, n);
        check("rcfg_rst_len", 64'(n), 64'd4);
        n = 0;
        while (!cfg_ready && n < 50) begin
            step(1);
            n++;
        end
        check("rcfg_ready_wait", 64'(cyc - t), 64'd9);

        // Broadcast to all five outputs.
        send(3'd7, 10'd200, 10'd150, 13'd64, 1'b1, EV_DONE, 2'd0, 8);
        check_dyn("bcast_next");
        wait_idle(40, "bcast");

        // Illegal targets 5 and 6: err pulse, nothing changes, stay in IDLE.
        send(3'd5, 10'd1, 10'd2, 13'd3, 1'b1, EV_ERR, 2'd1, 1);
        check("ill5_busy", 64'(busy), 64'd0);
        check("ill5_pll_rst", 64'(pll_rst), 64'd0);
        check("ill5_ready", 64'(cfg_ready), 64'd1);
        check_dyn("ill5");
        send(3'd6, 10'd4, 10'd5, 13'd6, 1'b1, EV_ERR, 2'd1, 1);
        check("ill6_locked", 64'(locked), 64'd1);
        check_dyn("ill6");

        // Timeout: three attempts of 4 reset cycles + 20 wait cycles, then FAIL.
        pll_lock = 1'b0;
        send(3'd0, 10'd50, 10'd60, 13'd70, 1'b1, EV_ERR, 2'd2, 73);
        for (int k = 0; k < 3; k++) begin
            run_len(1'b1, n);
            check($sformatf("to_rst_len%0d", k), 64'(n), 64'd4);
            run_len(1'b0, n);
            check($sformatf("to_wait_len%0d", k), 64'(n), 64'd20);
        end
        check("fail_pll_pwd", 64'(pll_pwd), 64'd1);
        check("fail_pll_rst", 64'(pll_rst), 64'd1);
        check("fail_busy", 64'(busy), 64'd0);
        check("fail_ready", 64'(cfg_ready), 64'd1);
        step(3);
        check("fail_hold_pwd", 64'(pll_pwd), 64'd1);
        check("fail_hold_code", 64'(err_code), 64'd2);

        // Recovery from FAIL with a legal request.
        pll_lock = 1'b1;
        send(3'd4, 10'd300, 10'd310, 13'd320, 1'b1, EV_DONE, 2'd0, 8);
        check("recover_pwd", 64'(pll_pwd), 64'd0);
        check("recover_pll_rst", 64'(pll_rst), 64'd1);
        check_dyn("recover_next");
        wait_idle(40, "recover");

        // Lock glitch 1,1,0 during WAIT_LOCK restarts settling: done 3 cycles late.
        pll_lock = 1'b0;
        send(3'd3, 10'd111, 10'd122, 13'd133, 1'b1, EV_DONE, 2'd0, 11);
        step(2);
        pll_lock = 1'b1;
        step(2);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        wait_idle(40, "glitch");

        // Lock loss in IDLE; a request in the detection cycle is not accepted.
        t        = cyc;
        pll_lock = 1'b0;
        step(1);
        check("loss_ready_before", 64'(cfg_ready), 64'd1);
        step(1);
        check("loss_ready_detect", 64'(cfg_ready), 64'd0);
        push_ev(EV_LOST, 2'd0, 1'b1, t + 3);
        push_ev(EV_DONE, 2'd0, 1'b1, t + 10);
        cfg_valid = 1'b1;
        cfg_sel   = 3'd0;
        cfg_odiv  = 10'd999;
        cfg_duty  = 10'd998;
        cfg_phase = 13'd997;
        step(1);
        cfg_valid = 1'b0;
        pll_lock  = 1'b1;
        check("loss_pll_rst", 64'(pll_rst), 64'd1);
        check("loss_busy", 64'(busy), 64'd1);
        check_dyn("loss");
        wait_idle(40, "relock");

        // Reset during WAIT_LOCK after reconfiguring output 1.
        pll_lock = 1'b0;
        send(3'd1, 10'd222, 10'd233, 13'd244, 1'b0, EV_DONE, 2'd0, 0);
        step(6);
        check("midrst_in_wait", 64'({busy, pll_rst}), 64'b10);
        rst = 1'b1;
        model_defaults();
        step(1);
        check("midrst_pll_rst", 64'(pll_rst), 64'd1);
        check("midrst_busy", 64'(busy), 64'd1);
        check("midrst_locked", 64'(locked), 64'd0);
        check("midrst_ready", 64'(cfg_ready), 64'd0);
        check_dyn("midrst");
        step(2);
        rst      = 1'b0;
        pll_lock = 1'b1;
        t        = cyc;
        push_ev(EV_DONE, 2'd0, 1'b1, t + 7);
        run_len(1'b1, n);
        check("midrst_rst_len", 64'(n), 64'd4);
        wait_idle(40, "midrst");

        step(3);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
